// File: rtl/rr_arb_mux.sv
// N-channel registered mux, round-robin or fixed select; 1-cycle latency.
// Backpressure: all in_ready bits stay 0 while the output word stalls (out_valid & !out_ready).
module rr_arb_mux #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [CW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [CW-1:0] ptr;
  logic [N-1:0]  grant;
  logic [CW-1:0] gidx;
  logic          gvld;
  logic          load;

  assign load = !out_valid || out_ready;

  always_comb begin
    grant = '0;
    gidx  = '0;
    gvld  = 1'b0;
    if (!mode) begin
      // Search starts just past the last winner so every requester gets a turn.
      for (int k = 1; k <= N; k++) begin
        if (!gvld && in_valid[(int'(ptr) + k) % N]) begin
          gvld = 1'b1;
          gidx = CW'((int'(ptr) + k) % N);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sel == CW'(i) && in_valid[i]) begin
          gvld = 1'b1;
          gidx = CW'(i);
        end
      end
    end
    if (gvld) grant[gidx] = 1'b1;
  end

  assign in_ready = {N{load & rst_n}} & grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= CW'(N - 1);
    end else if (load) begin
      out_valid <= gvld;
      if (gvld) begin
        out_data <= in_data[int'(gidx)*W +: W];
        out_chan <= gidx;
        if (!mode) ptr <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (N=4, W=8) with hand-computed expectations.
module tb_rr_arb_mux;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [CW-1:0]  sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arb_mux #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int ch, input logic [7:0] dat);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_chan"}, 32'(out_chan), 32'(ch));
    chk({tag, "_data"}, 32'(out_data), 32'(dat));
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_data   = {8'h08, 8'h04, 8'h02, 8'h01};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;

    // Fixed select walks each channel.
    mode = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = CW'(s);
      #1;
      chk("fix_rdy", 32'(in_ready), 32'(4'b0001 << s));
      step();
      chk_out("fix", s, 8'h01 << s);
    end

    // Round-robin fairness: ptr still N-1, so ch0 first.
    mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_rdy", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      step();
      chk_out("rr", k % 4, 8'h01 << (k % 4));
    end

    // Sparse: grant ch0 then ch1, then only 1 and 3 request.
    step();
    chk_out("sp0", 0, 8'h01);
    step();
    chk_out("sp1", 1, 8'h02);
    in_valid = 4'b1010;
    #1;
    chk("sp_rdy3", 32'(in_ready), 32'(4'b1000));
    step();
    chk_out("sp3", 3, 8'h08);
    chk("sp_rdy1", 32'(in_ready), 32'(4'b0010));
    step();
    chk_out("sp1b", 1, 8'h02);

    // Backpressure: hold ch1's word for 3 cycles.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_rdy", 32'(in_ready), 32'd0);
      step();
      chk_out("bp_hold", 1, 8'h02);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 32'(4'b0100));
    step();
    chk_out("bp_rel", 2, 8'h04);

    // Fixed mode, selected channel not valid: word drains, output goes idle.
    mode     = 1'b1;
    sel      = 2'd2;
    in_valid = 4'b1011;
    #1;
    chk("inv_rdy", 32'(in_ready), 32'd0);
    step();
    chk("inv_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    #1;
    chk("inv_rdy_idle", 32'(in_ready), 32'd0);

    // Mid-stream reset: ptr=2 so RR picks ch3, then reset clears it.
    out_ready = 1'b1;
    mode      = 1'b0;
    in_valid  = 4'b1111;
    step();
    chk_out("pre_rst", 3, 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(in_ready), 32'(4'b0001));
    step();
    chk_out("post_rst", 0, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
